// File: rtl/beam_thresholds_wb_if.sv
// rtl/beam_thresholds_wb_if.sv - Wishbone slave bundle for the beam threshold store
interface beam_thresholds_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [11:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/beam_thresholds_wb.sv
// rtl/beam_thresholds_wb.sv - Wishbone threshold store, serial cascade loader and scaler timer
module beam_thresholds_wb #(
  parameter int          NBEAMS         = 54,
  parameter logic [17:0] THRESH_DEFAULT = 18'h3FFFF,
  parameter logic [31:0] PERIOD_DEFAULT = 32'd125000000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  beam_thresholds_wb_if.slave wb,
  input  logic                scal_bank_i,
  output logic                scal_timer_o,
  output logic                scal_rst_o,
  output logic [35:0]         thresh_o,
  output logic [1:0]          thresh_wr_o,
  output logic [1:0]          thresh_update_o
);
  localparam int IW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  logic [17:0]   thresh_mem [NBEAMS];
  logic [17:0]   subthr_mem [NBEAMS];
  logic [31:0]   period_q;
  logic [31:0]   timer_cnt;
  logic [31:0]   period_eff;
  logic          scal_rst_q;
  logic          scal_rst_nxt;
  logic          timer_q;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic [31:0]   rd_data;
  state_t        state_q, state_d;
  logic [IW-1:0] beam_q, beam_d;

  logic          req, wr_en;
  logic [6:0]    a_idx;
  logic [IW-1:0] a_beam;
  logic          a_in_range;
  logic          hit_thr, hit_sub, hit_ctrl, hit_period;
  logic          busy;
  logic          unused_ok;

  // ack_q blocks the request term so a held strobe is acked every other cycle
  assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_en      = req & wb.wb_we_i;
  assign a_idx      = wb.wb_adr_i[8:2];
  assign a_beam     = a_idx[IW-1:0];
  assign a_in_range = (32'(a_idx) < NBEAMS);
  assign hit_thr    = (wb.wb_adr_i[11:9] == 3'b000) & a_in_range;
  assign hit_sub    = (wb.wb_adr_i[11:9] == 3'b001) & a_in_range;
  assign hit_ctrl   = (wb.wb_adr_i[11:2] == 10'h200);
  assign hit_period = (wb.wb_adr_i[11:2] == 10'h201);
  assign busy       = (state_q != ST_IDLE);
  assign unused_ok  = ^{wb.wb_sel_i, wb.wb_adr_i[1:0]};

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;
  assign scal_rst_o  = scal_rst_q;
  assign scal_timer_o = timer_q;

  always_comb begin
    rd_data = '0;
    if (hit_thr)
      rd_data = {14'b0, thresh_mem[a_beam]};
    else if (hit_sub)
      rd_data = {14'b0, subthr_mem[a_beam]};
    else if (hit_ctrl)
      rd_data = {23'b0, scal_bank_i, 6'b0, scal_rst_q, busy};
    else if (hit_period)
      rd_data = period_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NBEAMS; i++) begin
        thresh_mem[i] <= THRESH_DEFAULT;
        subthr_mem[i] <= THRESH_DEFAULT;
      end
    end else if (wr_en) begin
      if (hit_thr) thresh_mem[a_beam] <= wb.wb_dat_i[17:0];
      if (hit_sub) subthr_mem[a_beam] <= wb.wb_dat_i[17:0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      scal_rst_q <= 1'b0;
      period_q   <= PERIOD_DEFAULT;
    end else begin
      ack_q      <= req;
      dat_q      <= req ? rd_data : '0;
      scal_rst_q <= scal_rst_nxt;
      if (wr_en && hit_period) period_q <= wb.wb_dat_i;
    end
  end

  assign scal_rst_nxt = (wr_en && hit_ctrl) ? wb.wb_dat_i[1] : scal_rst_q;
  assign period_eff   = (period_q == '0) ? 32'd1 : period_q;

  // Holding on either edge of SCAL_RST keeps pulses out of every cycle where it reads 1
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      timer_cnt <= '0;
      timer_q   <= 1'b0;
    end else if (scal_rst_q || scal_rst_nxt || (wr_en && hit_period)) begin
      timer_cnt <= '0;
      timer_q   <= 1'b0;
    end else if (timer_cnt >= period_eff - 32'd1) begin
      timer_cnt <= '0;
      timer_q   <= 1'b1;
    end else begin
      timer_cnt <= timer_cnt + 32'd1;
      timer_q   <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      beam_q  <= '0;
    end else begin
      state_q <= state_d;
      beam_q  <= beam_d;
    end
  end

  // Memories are read at presentation time, so writes to beams not yet shifted still go out
  always_comb begin
    state_d         = state_q;
    beam_d          = beam_q;
    thresh_o        = '0;
    thresh_wr_o     = 2'b00;
    thresh_update_o = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (wr_en && hit_ctrl && wb.wb_dat_i[0]) begin
          state_d = ST_SHIFT;
          beam_d  = IW'(NBEAMS - 1);
        end
      end
      ST_SHIFT: begin
        thresh_o    = {subthr_mem[beam_q], thresh_mem[beam_q]};
        thresh_wr_o = 2'b11;
        if (beam_q == '0)
          state_d = ST_COMMIT;
        else
          beam_d = beam_q - 1'b1;
      end
      ST_COMMIT: begin
        thresh_update_o = 2'b11;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_beam_thresholds_wb.sv
// tb/tb_beam_thresholds_wb.sv - randomized self-checking bench for beam_thresholds_wb
module tb_beam_thresholds_wb;
  localparam int NB = 54;

  logic        clk = 1'b0;
  logic        rst;
  logic        scal_bank;
  logic        scal_timer;
  logic        scal_rst;
  logic [35:0] thresh;
  logic [1:0]  twr;
  logic [1:0]  tupd;

  always #5 clk = ~clk;

  beam_thresholds_wb_if bus();

  beam_thresholds_wb #(.NBEAMS(NB)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wb              (bus),
    .scal_bank_i     (scal_bank),
    .scal_timer_o    (scal_timer),
    .scal_rst_o      (scal_rst),
    .thresh_o        (thresh),
    .thresh_wr_o     (twr),
    .thresh_update_o (tupd)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int last_ack_cyc;
  int last_ack_lat;

  int          log_cyc[$];
  logic [1:0]  log_wr[$];
  logic [1:0]  log_upd[$];
  logic [35:0] log_dat[$];
  int          pulse_cyc[$];

  logic [17:0] thr_m [NB];
  logic [17:0] sub_m [NB];
  logic [35:0] exp_load [NB];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (twr != 2'b00 || tupd != 2'b00) begin
      log_cyc.push_back(cycle);
      log_wr.push_back(twr);
      log_upd.push_back(tupd);
      log_dat.push_back(thresh);
    end
    if (scal_timer) pulse_cyc.push_back(cycle);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [11:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    int n;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = wdat;
    n = 0;
    rdat = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 8);
    if (!bus.wb_ack_o) check("ack_timeout", 0, 1);
    else begin
      rdat = bus.wb_dat_o;
      last_ack_cyc = cycle;
      last_ack_lat = n;
    end
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [11:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, adr, d, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [11:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(1'b0, adr, 32'h0, d);
    check(tag, d, exp);
  endtask

  task automatic clear_logs();
    log_cyc.delete();
    log_wr.delete();
    log_upd.delete();
    log_dat.delete();
  endtask

  task automatic snapshot_model();
    for (int n = 0; n < NB; n++) exp_load[n] = {sub_m[n], thr_m[n]};
  endtask

  task automatic check_load();
    check("load_len", log_cyc.size(), NB + 1);
    if (log_cyc.size() == NB + 1) begin
      for (int k = 0; k < NB; k++) begin
        check("load_wr", log_wr[k], 2'b11);
        check("load_upd_low", log_upd[k], 2'b00);
        check("load_dat", log_dat[k], exp_load[NB - 1 - k]);
        check("load_seq", log_cyc[k] - log_cyc[0], k);
      end
      check("commit_upd", log_upd[NB], 2'b11);
      check("commit_wr", log_wr[NB], 2'b00);
      check("commit_seq", log_cyc[NB] - log_cyc[0], NB);
    end
  endtask

  task automatic expect_pulses(input string tag, input int p0, input int step);
    int n_exp;
    @(posedge clk); #2;
    n_exp = (cycle - 1 - p0) / step;
    check({tag, "_count"}, pulse_cyc.size(), n_exp);
    for (int k = 0; k < n_exp && k < pulse_cyc.size(); k++)
      check({tag, "_at"}, pulse_cyc[k] - p0, (k + 1) * step);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int p0;
    logic [17:0] v0, vl;

    rst = 1'b1;
    scal_bank = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = 4'hF;
    for (int n = 0; n < NB; n++) begin
      thr_m[n] = 18'h3FFFF;
      sub_m[n] = 18'h3FFFF;
    end

    repeat (3) @(negedge clk);
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    check("rst_wr", twr, 0);
    check("rst_upd", tupd, 0);
    check("rst_thresh", thresh, 0);
    check("rst_timer", scal_timer, 0);
    check("rst_scal_rst", scal_rst, 0);
    @(posedge clk); #1 rst = 1'b0;

    rd_check("rd_thr0_default", 12'h000, 32'h0003FFFF);
    check("ack_latency", last_ack_lat, 2);
    rd_check("rd_sub_last_default", 12'(12'h200 + 4 * (NB - 1)), 32'h0003FFFF);
    rd_check("rd_period_default", 12'h804, 32'd125000000);

    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 12'h000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ack_hold_pattern", bus.wb_ack_o, k % 2);
    end
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;

    wb_write(12'h008, 32'h00012345); thr_m[2] = 18'h12345;
    wb_write(12'h208, 32'h00000ABC); sub_m[2] = 18'h00ABC;
    rd_check("rd_thr2", 12'h008, 32'h00012345);
    rd_check("rd_sub2", 12'h208, 32'h00000ABC);
    wb_write(12'h000, 32'hFFFFFFFF); thr_m[0] = 18'h3FFFF;
    rd_check("rd_thr0_trunc", 12'h000, 32'h0003FFFF);
    wb_write(12'(4 * NB), 32'd5);
    rd_check("rd_beam_oob", 12'(4 * NB), 32'h0);
    rd_check("rd_unmapped", 12'h400, 32'h0);
    rd_check("rd_unmapped2", 12'h808, 32'h0);

    for (int k = 0; k < 60; k++) begin
      int region, idx;
      logic [11:0] a;
      logic [31:0] v;
      region = $urandom_range(0, 1);
      idx    = $urandom_range(0, NB + 3);
      a      = 12'(region * 512 + idx * 4);
      v      = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wb_write(a, v);
        if (idx < NB) begin
          if (region == 0) thr_m[idx] = v[17:0];
          else sub_m[idx] = v[17:0];
        end
      end else begin
        wb_access(1'b0, a, 32'h0, d);
        if (idx >= NB) check("rand_rd_oob", d, 0);
        else if (region == 0) check("rand_rd_thr", d, {14'b0, thr_m[idx]});
        else check("rand_rd_sub", d, {14'b0, sub_m[idx]});
      end
    end
    for (int n = 0; n < NB; n++) begin
      rd_check("scan_thr", 12'(4 * n), {14'b0, thr_m[n]});
      rd_check("scan_sub", 12'(12'h200 + 4 * n), {14'b0, sub_m[n]});
    end

    for (int n = 0; n < NB; n++) begin
      wb_write(12'(4 * n), 32'(n));
      wb_write(12'(12'h200 + 4 * n), 32'(12'h100 + n));
      thr_m[n] = 18'(n);
      sub_m[n] = 18'(12'h100 + n);
    end
    snapshot_model();
    clear_logs();
    wb_write(12'h800, 32'h1);
    rd_check("ctrl_busy", 12'h800, 32'h1);
    wb_write(12'h800, 32'h1);
    v0 = 18'($urandom);
    vl = 18'($urandom);
    wb_write(12'h000, {14'b0, v0});
    thr_m[0] = v0;
    exp_load[0][17:0] = v0;
    wb_write(12'(4 * (NB - 1)), {14'b0, vl});
    thr_m[NB - 1] = vl;
    repeat (NB + 10) @(posedge clk);
    rd_check("ctrl_idle", 12'h800, 32'h0);
    check_load();
    @(negedge clk);
    check("thresh_idle_zero", thresh, 0);

    snapshot_model();
    clear_logs();
    wb_write(12'h800, 32'h1);
    repeat (NB + 10) @(posedge clk);
    check_load();

    pulse_cyc.delete();
    wb_write(12'h804, 32'd10);
    p0 = last_ack_cyc;
    repeat (45) @(posedge clk);
    expect_pulses("timer10", p0, 10);

    wb_write(12'h800, 32'h2);
    check("scal_rst_set", scal_rst, 1);
    rd_check("ctrl_scal_rst", 12'h800, 32'h2);
    pulse_cyc.delete();
    repeat (30) @(posedge clk);
    check("timer_held", pulse_cyc.size(), 0);
    wb_write(12'h800, 32'h0);
    check("scal_rst_clr", scal_rst, 0);
    p0 = last_ack_cyc;
    pulse_cyc.delete();
    repeat (25) @(posedge clk);
    expect_pulses("timer_release", p0, 10);

    wb_write(12'h804, 32'd0);
    p0 = last_ack_cyc;
    pulse_cyc.delete();
    repeat (6) @(posedge clk);
    expect_pulses("timer0", p0, 1);
    wb_write(12'h804, 32'd1000);

    scal_bank = 1'b1;
    rd_check("ctrl_bank", 12'h800, 32'h100);

    wb_write(12'h800, 32'h1);
    repeat (5) @(posedge clk);
    #1 check("midload_wr", twr, 2'b11);
    rst = 1'b1;
    #1;
    check("abort_wr", twr, 0);
    check("abort_upd", tupd, 0);
    check("abort_thresh", thresh, 0);
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (NB + 5) @(posedge clk);
    check("abort_no_strobes", log_cyc.size(), 0);
    rd_check("post_rst_thr2", 12'h008, 32'h0003FFFF);
    rd_check("post_rst_sub_last", 12'(12'h200 + 4 * (NB - 1)), 32'h0003FFFF);
    rd_check("post_rst_period", 12'h804, 32'd125000000);
    rd_check("post_rst_ctrl", 12'h800, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
